// File: rtl/seg7_capture_encoder_if.sv
// Multiplexed two-digit 7-segment capture bus.
// The master drives segments and digit select; the slave returns the decoded value and status pulses.
interface seg7_capture_encoder_if;
  logic [6:0] seg_in;
  logic [1:0] dig_sel;
  logic [3:0] binary_out;
  logic       valid;
  logic       err;

  modport master (output seg_in, dig_sel, input binary_out, valid, err);
  modport slave  (input seg_in, dig_sel, output binary_out, valid, err);
endinterface

// File: rtl/seg7_capture_encoder.sv
// Captures a multiplexed dual 7-segment display, debounces each digit and rebuilds the 4-bit value.
// state  | meaning
// WAIT_U | waiting for a stable units digit
// WAIT_T | units held, waiting for a stable tens digit (timeout running)
// EMIT   | combine tens*10+units, pulse valid or err
module seg7_capture_encoder #(
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input logic                   clk,
  input logic                   rst_n,
  seg7_capture_encoder_if.slave bus
);

  localparam logic [7:0]  STABLE_LAST  = 8'(STABLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {WAIT_U, WAIT_T, EMIT} state_t;

  // Returns {invalid, digit}; blank is legal only for the tens position.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg, input logic allow_blank);
    logic [4:0] dec;
    case (seg)
      7'b1000000: dec = {1'b0, 4'd0};
      7'b1111001: dec = {1'b0, 4'd1};
      7'b0100100: dec = {1'b0, 4'd2};
      7'b0110000: dec = {1'b0, 4'd3};
      7'b0011001: dec = {1'b0, 4'd4};
      7'b0010010: dec = {1'b0, 4'd5};
      7'b0000010: dec = {1'b0, 4'd6};
      7'b1111000: dec = {1'b0, 4'd7};
      7'b0000000: dec = {1'b0, 4'd8};
      7'b0010000: dec = {1'b0, 4'd9};
      7'b1111111: dec = allow_blank ? {1'b0, 4'd0} : {1'b1, 4'd0};
      default:    dec = {1'b1, 4'd0};
    endcase
    return dec;
  endfunction

  logic [6:0]  r_seg_q;
  logic [1:0]  r_sel_q;
  logic [6:0]  r_seg_prev;
  logic [1:0]  r_sel_prev;
  logic [7:0]  r_cnt;
  logic        r_done;
  logic        r_acc;
  logic [6:0]  r_acc_seg;
  logic        r_acc_tens;

  state_t      r_state;
  logic [3:0]  r_units;
  logic [3:0]  r_tens;
  logic [15:0] r_to_cnt;
  logic [3:0]  r_binary_out;
  logic        r_valid;
  logic        r_err;

  logic        w_same;
  logic        w_illegal;
  logic        w_sel_ok;
  logic [7:0]  w_cnt_next;
  logic        w_held;
  logic        w_acc_set;
  logic [4:0]  w_u_dec;
  logic [4:0]  w_t_dec;
  logic [4:0]  w_value;

  assign w_same    = (r_seg_q == r_seg_prev) && (r_sel_q == r_sel_prev);
  assign w_illegal = (r_sel_q == 2'b11);
  assign w_sel_ok  = (r_sel_q == 2'b01) || (r_sel_q == 2'b10);

  always_comb begin
    w_cnt_next = 8'd0;
    if (!w_illegal && w_same)
      w_cnt_next = (r_cnt == STABLE_LAST) ? r_cnt : 8'(r_cnt + 8'd1);
  end

  // A digit already accepted stays blocked until its pattern or select changes.
  assign w_held    = w_same && r_done && !w_illegal;
  assign w_acc_set = w_sel_ok && (w_cnt_next == STABLE_LAST) && !w_held;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q    <= '1;
      r_sel_q    <= '0;
      r_seg_prev <= '1;
      r_sel_prev <= '0;
      r_cnt      <= '0;
      r_done     <= 1'b0;
      r_acc      <= 1'b0;
      r_acc_seg  <= '0;
      r_acc_tens <= 1'b0;
    end else begin
      r_seg_q    <= bus.seg_in;
      r_sel_q    <= bus.dig_sel;
      r_seg_prev <= r_seg_q;
      r_sel_prev <= r_sel_q;
      r_cnt      <= w_cnt_next;
      r_done     <= w_acc_set | w_held;
      r_acc      <= w_acc_set;
      if (w_acc_set) begin
        r_acc_seg  <= r_seg_q;
        r_acc_tens <= r_sel_q[1];
      end
    end
  end

  assign w_u_dec = decode_seg(r_acc_seg, 1'b0);
  assign w_t_dec = decode_seg(r_acc_seg, 1'b1);
  assign w_value = ({1'b0, r_tens} * 5'd10) + {1'b0, r_units};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_U;
      r_units      <= '0;
      r_tens       <= '0;
      r_to_cnt     <= '0;
      r_binary_out <= '0;
      r_valid      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        WAIT_U: begin
          if (r_acc && !r_acc_tens) begin
            if (w_u_dec[4]) begin
              r_err <= 1'b1;
            end else begin
              r_units  <= w_u_dec[3:0];
              r_to_cnt <= '0;
              r_state  <= WAIT_T;
            end
          end
        end
        WAIT_T: begin
          r_to_cnt <= r_to_cnt + 16'd1;
          if (r_to_cnt == TIMEOUT_LAST) begin
            r_err   <= 1'b1;
            r_state <= WAIT_U;
          end else if (r_acc && !r_acc_tens) begin
            if (!w_u_dec[4] && (w_u_dec[3:0] != r_units)) begin
              r_units  <= w_u_dec[3:0];
              r_to_cnt <= '0;
            end
          end else if (r_acc && r_acc_tens) begin
            if (w_t_dec[4] || (w_t_dec[3:0] > 4'd1)) begin
              r_err   <= 1'b1;
              r_state <= WAIT_U;
            end else begin
              r_tens  <= w_t_dec[3:0];
              r_state <= EMIT;
            end
          end
        end
        EMIT: begin
          if (w_value <= 5'd15) begin
            r_binary_out <= w_value[3:0];
            r_valid      <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= WAIT_U;
        end
        default: r_state <= WAIT_U;
      endcase
    end
  end

  assign bus.binary_out = r_binary_out;
  assign bus.valid      = r_valid;
  assign bus.err        = r_err;

endmodule

// File: doc/seg7_capture_encoder.md
Name: seg7_capture_encoder

Overview:
- Reverse path of the binary-to-dual-7-segment decoder.
- Samples a multiplexed two-digit 7-segment bus: one shared segment vector plus one-hot digit select.
- Debounces each digit, maps the segment patterns back to BCD, then recombines tens and units into the original 4-bit value (0..15).
- Used for loopback self-check of the display path and for reading externally driven displays.

Parameters:
STABLE_CYCLES, 4, consecutive clocks a digit pattern must stay unchanged before it is accepted (range 1..255).
TIMEOUT_CYCLES, 1000, max clocks from units accepted to tens accepted before the frame is aborted (range 2..65535).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment pattern, active-low; bit0=a … bit6=g
dig_sel  input  2  one-hot digit select; bit0=units (seg0), bit1=tens (seg1); 2'b00 = no digit driven
binary_out  output  4  reconstructed value, held until next valid frame
valid  output  1  one-cycle pulse when binary_out is updated
err  output  1  one-cycle pulse on an invalid pattern, out-of-range value or timeout

Behaviour:
- Reset (async, rst_n=0): binary_out=0, valid=0, err=0, FSM=WAIT_U, counters=0, captured digits=0. Deasserting rst_n mid-frame discards any partial capture.
- Segment map (seg_in[6:0] → digit): 1000000→0, 1111001→1, 0100100→2, 0110000→3, 0011001→4, 0010010→5, 0000010→6, 1111000→7, 0000000→8, 0010000→9.
- Tens digit also accepts blank 1111111 as 0. Any other pattern is INVALID.
- Inputs are registered once before use. All latencies below are measured from the registered inputs.
- Stability filter:
  - The counter resets whenever seg_in or dig_sel differs from the previous registered sample.
  - The counter increments while both are unchanged.
  - The digit is accepted on the cycle the counter reaches STABLE_CYCLES-1, i.e. after STABLE_CYCLES equal samples.
- dig_sel=2'b11 is illegal: the filter is held in reset and the FSM state is unchanged. No err.
- FSM states:
  - WAIT_U: waits for dig_sel=01 with a stable pattern. Valid digit → store units, go WAIT_T, clear timeout counter. INVALID → err pulse, stay.
  - WAIT_T: waits for dig_sel=10 with a stable pattern.
    - Timeout counter increments every cycle. Reaching TIMEOUT_CYCLES → err pulse, go WAIT_U.
    - Stable dig_sel=01 with a different valid units pattern → replace units, restart timeout.
    - Stable tens digit INVALID or >1 → err, go WAIT_U.
    - Otherwise store tens, go EMIT.
  - EMIT, one cycle:
    - Computes value = tens*10 + units in 5 bits.
    - value≤15 → binary_out=value[3:0], valid=1.
    - value>15 (tens=1, units 6..9) → err=1, binary_out unchanged.
    - Always returns to WAIT_U.
- After acceptance, the same still-stable digit is not re-accepted until its pattern or dig_sel changes. This prevents a held units digit from re-triggering in WAIT_U.
- valid and err are never asserted in the same cycle.
- Latency from the tens digit becoming stable to the valid pulse: STABLE_CYCLES + 2 clocks. This is fixed and checked by the bench.

Test Plan:
- Full sweep: for each v=0..15, drive units pattern (dig_sel=01) for 8 clocks, then tens pattern (dig_sel=10) for 8 clocks, with STABLE_CYCLES=4 → exactly one valid per frame, binary_out=v. Example: v=13 uses units 0110000, tens 1111001.
- Blank tens: units 0010010 (5), tens 1111111 → binary_out=5, valid pulse.
- Glitch rejection: units pattern toggles between 0000000 and 0010000 every 2 clocks for 20 clocks → no acceptance, no valid/err. Then stable 0010000 followed by tens "0" → binary_out=9.
- Range/invalid: units 0000010 (6) with tens "1" → err pulse, binary_out keeps its previous value. Units pattern 0101010 → err pulse while in WAIT_U.
- Timeout: TIMEOUT_CYCLES=20, valid units "3", then dig_sel=00 for 25 clocks → err exactly 20 clocks after units accepted. A following tens digit alone produces nothing.
- Reset mid-frame: units "7" accepted, pull rst_n low asynchronously between clock edges → outputs 0 immediately. After release, tens "1" alone produces no valid.
